// File: rtl/paralelo_serial_param.sv
// Parallel-to-serial converter with a one-word valid/ready holding buffer,
// a fixed word grid and a run of SYNC_WORDS idle words after every reset.
module paralelo_serial_param #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD  = 'hBC,
  parameter bit               MSB_FIRST  = 1'b1,
  parameter int               SYNC_WORDS = 4
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             data_paralelo_serial,
  output logic             word_start,
  output logic             idle_out,
  output logic             sync_done
);

  localparam int CW = $clog2(WIDTH);
  localparam int SW = (SYNC_WORDS > 0) ? $clog2(SYNC_WORDS + 1) : 1;

  typedef enum logic {SYNC, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    sync_cnt_q, sync_cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             bit_q, bit_d;
  logic             ws_q, ws_d;
  logic             idle_q, idle_d;
  logic             boundary, run_now, xfer;
  logic [CW-1:0]    idx;
  logic [WIDTH-1:0] word_sel;

  // cnt_q holds the index of the bit the next edge emits; 0 means a new word starts.
  assign boundary  = (cnt_q == '0);
  assign ready_out = !hold_full_q && !reset;
  assign xfer      = valid_in && ready_out;

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == CW'(WIDTH - 1)) ? '0 : cnt_q + CW'(1);
    sync_cnt_d  = sync_cnt_q;
    word_d      = word_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    ws_d        = boundary;
    idle_d      = idle_q;
    word_sel    = word_q;
    run_now     = 1'b0;

    if (boundary) begin
      run_now = (state_q == RUN) || (sync_cnt_q == SW'(SYNC_WORDS));
      if (run_now) state_d = RUN;
      else         sync_cnt_d = sync_cnt_q + SW'(1);
      if (run_now && hold_full_q) begin
        word_sel    = hold_q;
        hold_full_d = 1'b0;
        idle_d      = 1'b0;
      end else begin
        word_sel = IDLE_WORD;
        idle_d   = 1'b1;
      end
      word_d = word_sel;
    end

    // ready_out implies an empty buffer, so this never collides with the drain above.
    if (xfer) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end

    idx   = MSB_FIRST ? (CW'(WIDTH - 1) - cnt_q) : cnt_q;
    bit_d = word_sel[idx];
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q     <= SYNC;
      cnt_q       <= '0;
      sync_cnt_q  <= '0;
      word_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_q       <= 1'b0;
      ws_q        <= 1'b0;
      idle_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_cnt_q  <= sync_cnt_d;
      word_q      <= word_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_q       <= bit_d;
      ws_q        <= ws_d;
      idle_q      <= idle_d;
    end
  end

  assign data_paralelo_serial = bit_q;
  assign word_start           = ws_q;
  assign idle_out             = idle_q;
  assign sync_done            = (state_q == RUN);

endmodule

// File: tb/tb_paralelo_serial_param.sv
// Random-stimulus bench for two configurations of paralelo_serial_param,
// compared cycle by cycle against a word-level reference model.
module tb_paralelo_serial_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] din0;
  logic [9:0] din1;
  logic       vld0, vld1;
  logic       rdy0, ser0, ws0, idle0, sd0;
  logic       rdy1, ser1, ws1, idle1, sd1;

  paralelo_serial_param dut0 (
    .clk_32f(clk), .reset(reset), .data_in(din0), .valid_in(vld0),
    .ready_out(rdy0), .data_paralelo_serial(ser0), .word_start(ws0),
    .idle_out(idle0), .sync_done(sd0)
  );

  paralelo_serial_param #(
    .WIDTH(10), .IDLE_WORD(10'h17C), .MSB_FIRST(1'b0), .SYNC_WORDS(0)
  ) dut1 (
    .clk_32f(clk), .reset(reset), .data_in(din1), .valid_in(vld1),
    .ready_out(rdy1), .data_paralelo_serial(ser1), .word_start(ws1),
    .idle_out(idle1), .sync_done(sd1)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: per instance, position within the current word and the
  // number of words begun since reset; bits are picked arithmetically.
  int         W     [2] = '{8, 10};
  int         SWN   [2] = '{4, 0};
  bit         MSBF  [2] = '{1'b1, 1'b0};
  logic [15:0] IDLEW [2] = '{16'h00BC, 16'h017C};

  int          pos   [2];
  int          wn    [2];
  bit          hfull [2];
  logic [15:0] hdat  [2];
  logic [15:0] cur   [2];
  bit          cidle [2];
  bit          e_bit [2];
  bit          e_ws  [2];
  bit          e_idle[2];

  task automatic model_step(input int i, input bit rst, input bit v, input logic [15:0] d);
    bit rdy_pre;
    int b;
    if (rst) begin
      pos[i] = 0; wn[i] = 0; hfull[i] = 1'b0;
      e_bit[i] = 1'b0; e_ws[i] = 1'b0; e_idle[i] = 1'b0;
      return;
    end
    rdy_pre = !hfull[i];
    e_ws[i] = (pos[i] == 0);
    if (pos[i] == 0) begin
      if (wn[i] >= SWN[i] && hfull[i]) begin
        cur[i] = hdat[i]; cidle[i] = 1'b0; hfull[i] = 1'b0;
      end else begin
        cur[i] = IDLEW[i]; cidle[i] = 1'b1;
      end
      wn[i]++;
    end
    b = MSBF[i] ? (W[i] - 1 - pos[i]) : pos[i];
    e_bit[i]  = cur[i][b];
    e_idle[i] = cidle[i];
    pos[i]    = (pos[i] + 1) % W[i];
    if (v && rdy_pre) begin
      hdat[i] = d; hfull[i] = 1'b1;
    end
  endtask

  task automatic check_all();
    check_eq("ser0",  int'(ser0),  int'(e_bit[0]));
    check_eq("ws0",   int'(ws0),   int'(e_ws[0]));
    check_eq("idle0", int'(idle0), int'(e_idle[0]));
    check_eq("sd0",   int'(sd0),   int'(wn[0] > SWN[0]));
    check_eq("rdy0",  int'(rdy0),  int'(!hfull[0] && !reset));
    check_eq("ser1",  int'(ser1),  int'(e_bit[1]));
    check_eq("ws1",   int'(ws1),   int'(e_ws[1]));
    check_eq("idle1", int'(idle1), int'(e_idle[1]));
    check_eq("sd1",   int'(sd1),   int'(wn[1] > SWN[1]));
    check_eq("rdy1",  int'(rdy1),  int'(!hfull[1] && !reset));
  endtask

  // Drive inputs at the falling edge, advance the model at the rising edge,
  // then compare at the next falling edge.
  task automatic cycle(input bit r, input int pv);
    reset = r;
    vld0  = ($urandom_range(99) < pv);
    vld1  = ($urandom_range(99) < pv);
    din0  = 8'($urandom);
    din1  = 10'($urandom);
    @(posedge clk);
    model_step(0, reset, vld0, {8'h00, din0});
    model_step(1, reset, vld1, {6'h00, din1});
    @(negedge clk);
    check_all();
  endtask

  initial begin
    reset = 1'b1; vld0 = 1'b0; vld1 = 1'b0; din0 = '0; din1 = '0;
    @(negedge clk);
    for (int k = 0; k < 3; k++)  cycle(1'b1, 0);
    for (int k = 0; k < 40; k++) cycle(1'b0, 0);
    for (int k = 0; k < 60; k++) cycle(1'b0, 100);
    for (int k = 0; k < 200; k++) cycle(1'b0, 30);
    // Reset while a word shifts and another is buffered.
    for (int k = 0; k < 5; k++)  cycle(1'b0, 100);
    cycle(1'b1, 100);
    for (int k = 0; k < 50; k++) cycle(1'b0, 0);
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 2 + int'($urandom_range(37)); j++) cycle(1'b0, 100);
      cycle(1'b1, 50);
    end
    for (int k = 0; k < 12; k++) begin
      automatic int pv = int'($urandom_range(100));
      for (int j = 0; j < 60 + int'($urandom_range(140)); j++)
        cycle($urandom_range(199) == 0, pv);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/paralelo_serial_param.md
# paralelo_serial_param

Parametrised parallel-to-serial converter for the PCI physical-layer transmit path, successor to the fixed 8-bit serializer. It accepts WIDTH-bit words through a valid/ready handshake into a one-word holding buffer and shifts them out one bit per clock on the serial line. Word boundaries are fixed: data and idle never switch mid-word. After every reset it sends a programmable number of idle (comma) words for receiver alignment before it emits data.

## Interface
Parameters:
- WIDTH, 8, word width in bits; legal range is WIDTH ≥ 2.
- IDLE_WORD, 8'hBC (WIDTH bits), pattern sent whenever no data word is available.
- MSB_FIRST, 1, bit order: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- SYNC_WORDS, 4, number of idle words forced after reset; legal range is SYNC_WORDS ≥ 0.

Ports:
- clk_32f  input  1  serial bit clock; the single clock, all logic on its rising edge.
- reset  input  1  synchronous, active-high.
- data_in  input  WIDTH  parallel word.
- valid_in  input  1  data_in is valid.
- ready_out  output  1  holding buffer can accept a word.
- data_paralelo_serial  output  1  registered serial bit.
- word_start  output  1  high during the first bit of every word.
- idle_out  output  1  high while the current word is IDLE_WORD.
- sync_done  output  1  high once the SYNC_WORDS idle words have been sent.

## Operation
- "Cycle k" means the register values after clock edge k. Edge 0 is the first edge with reset low.
- States:
  - SYNC: entered from reset.
  - RUN: entered at the boundary edge that starts word SYNC_WORDS.
  - If SYNC_WORDS = 0, the block enters RUN at edge 0.
- Word n occupies cycles n·WIDTH … n·WIDTH+WIDTH-1.
- The bit counter runs from 0 to WIDTH-1 and wraps. Counter width is $clog2(WIDTH).
- The sync word counter has width $clog2(SYNC_WORDS+1). It saturates; it does not wrap.
- Word selection happens at each boundary edge (bit counter wraps to 0):
  - If the state is RUN, or becomes RUN at this edge, and the holding buffer is full: load the buffered word and clear the buffer at the same edge. Set idle_out = 0.
  - Otherwise: load IDLE_WORD and set idle_out = 1.
- Every edge outputs one bit of the loaded word, in the order given by MSB_FIRST.
- Handshake:
  - ready_out = !hold_full && !reset (combinational).
  - A transfer occurs on an edge where valid_in && ready_out; it captures data_in and sets hold_full.
  - With ready_out low, data_in and valid_in are ignored.
  - A transfer can never coincide with a drain, because the buffer is empty whenever ready_out is high.
- The buffer may fill during SYNC. Its word waits until the first RUN boundary.
- Reset values:
  - data_paralelo_serial = 0, word_start = 0, idle_out = 0, sync_done = 0, ready_out = 0.
  - Holding buffer is empty; counters are 0; state is SYNC.
- Reset mid-word: the current word is truncated and the buffered word is discarded. After reset release the block restarts SYNC from word 0.

## Timing
- Output is registered. The first serial bit appears in cycle 0 and is always IDLE_WORD's first bit, with word_start = 1 and idle_out = 1.
- word_start = 1 exactly in cycles n·WIDTH.
- sync_done rises in cycle SYNC_WORDS·WIDTH and stays high until reset.
- Latency from the transfer edge to the first data bit is 1 to WIDTH cycles in RUN. It is longer in SYNC, where the word waits for the first RUN boundary.
- ready_out returns high in the cycle the buffered word starts shifting.
- Sustained throughput is one word per WIDTH cycles with no idle gap, provided each next word is offered before the following boundary edge.
- The output changes only on clk_32f edges. No combinational path exists from data_in to data_paralelo_serial.

## Test plan
- Reset/idle (defaults, valid_in = 0):
  - Stream is 1,0,1,1,1,1,0,0 repeating from cycle 0.
  - word_start in cycles 0, 8, 16, …; idle_out = 1 throughout.
  - sync_done = 0 through cycle 31 and 1 from cycle 32.
- Single word in RUN: transfer 0x0F at edge 35.
  - ready_out = 0 in cycles 35–39.
  - Cycles 40–47 carry 0,0,0,0,1,1,1,1 with idle_out = 0; ready_out = 1 in cycle 40.
  - Idle resumes in cycle 48.
- Back-to-back: offer 0x01, 0x02, 0x03 with valid_in held high.
  - Output is 24 contiguous data bits 00000001 00000010 00000011 with word_start every 8 cycles and no idle word between them.
- Data during SYNC: transfer 0x3C at edge 5.
  - ready_out = 0 in cycles 5–31.
  - Word bits 0,0,1,1,1,1,0,0 appear in cycles 32–39 with idle_out = 0.
- Parameters WIDTH = 10, IDLE_WORD = 10'h17C, MSB_FIRST = 0, SYNC_WORDS = 0:
  - Idle stream is 0,0,1,1,1,1,1,0,1,0 repeating; sync_done = 1 in cycle 0.
  - Data 10'h001 appears as 1 followed by nine 0s.
- Reset mid-word: assert reset for one edge in cycle 44 while a data word is shifting with a second word buffered.
  - The next cycle shows all outputs at reset values.
  - After release the stream restarts with IDLE_WORD from bit 0; sync_done stays low for 32 cycles.
  - Neither data word is ever emitted.
